// File: rtl/term_key_pkg.sv
// ---------------------------------------------------------------------------
// term_key_pkg
// Shared types and constants for the terminal key decoder:
//   key_code_e   - key event codes carried on ev_code
//   state_e      - decoder FSM states
//   ASCII_*      - byte values recognised by the escape-sequence parser
//   csi_tilde_key - maps the digit of an "ESC [ n ~" sequence to its key
// ---------------------------------------------------------------------------
package term_key_pkg;

  typedef enum logic [3:0] {
    KEY_CHAR  = 4'd0,
    KEY_LEFT  = 4'd1,
    KEY_RIGHT = 4'd2,
    KEY_UP    = 4'd3,
    KEY_DOWN  = 4'd4,
    KEY_BS    = 4'd5,
    KEY_DEL   = 4'd6,
    KEY_ENTER = 4'd7,
    KEY_INS   = 4'd8,
    KEY_ESC   = 4'd9,
    KEY_HOME  = 4'd10,
    KEY_END   = 4'd11
  } key_code_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ESC       = 3'd1,
    ST_CSI       = 3'd2,
    ST_CSI_NUM   = 3'd3,
    ST_UTF8_CONT = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_DEL      = 8'h7F;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_O        = 8'h4F;
  localparam logic [7:0] ASCII_TILDE    = 8'h7E;

  // Digit '1'..'4' of "ESC [ n ~" selects HOME / INS / DEL / END.
  function automatic key_code_e csi_tilde_key(input logic [7:0] digit);
    case (digit)
      8'h31:   csi_tilde_key = KEY_HOME;
      8'h32:   csi_tilde_key = KEY_INS;
      8'h33:   csi_tilde_key = KEY_DEL;
      default: csi_tilde_key = KEY_END;
    endcase
  endfunction

endpackage

// File: rtl/term_esc_timer.sv
// ---------------------------------------------------------------------------
// term_esc_timer
// Idle counter used to decide that a lone ESC byte is a real ESC key press.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count (ESC byte accepted)
//   tick      - one idle cycle spent waiting in the ESC state
//   expire    - the count reaches ESC_TIMEOUT on this cycle, or already has
//   full      - the count sits at ESC_TIMEOUT (expired, not yet serviced)
// Parameters: ESC_TIMEOUT (idle cycles), CNT_W (counter width).
// ---------------------------------------------------------------------------
module term_esc_timer #(
  parameter int ESC_TIMEOUT = 1000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire,
  output logic full
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(ESC_TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(ESC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a timeout that cannot be serviced yet is remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && !full) begin
      cnt <= cnt + ONE;
    end
  end

  assign full   = (cnt == LIMIT);
  // Expiry is flagged on the idle cycle whose increment reaches LIMIT.
  assign expire = full || (tick && (cnt == LIMIT_M1));

endmodule

// File: rtl/term_key_decoder.sv
// ---------------------------------------------------------------------------
// term_key_decoder
// Turns a stream of terminal bytes into key events: printable ASCII, ENTER,
// backspace, arrows, HOME/END/INS/DEL from ESC/CSI/SS3 sequences, and a lone
// ESC after ESC_TIMEOUT idle cycles.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_data    - byte input, taken when in_valid && in_ready
//   in_ready            - byte accepted this cycle when high
//   ev_valid/ev_ready   - event output handshake (single output register)
//   ev_code             - key_code_e of the held event
//   ev_rune             - code point for KEY_CHAR, zero for other keys
//   err_pulse           - one-cycle pulse for a malformed or dropped byte
// Parameters: ESC_TIMEOUT, CNT_W (see term_esc_timer).
// Build option: define TERM_KEY_UTF8_EN to decode UTF-8 multi-byte
// characters; without it every byte >= 0x80 is reported as an error.
// ---------------------------------------------------------------------------
module term_key_decoder
  import term_key_pkg::*;
#(
  parameter int ESC_TIMEOUT = 1000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_code,
  output logic [20:0] ev_rune,
  output logic        err_pulse
);

`ifdef TERM_KEY_UTF8_EN
  localparam int RUNE_W = 21;
`else
  localparam int RUNE_W = 7;
`endif

  state_e            state;
  key_code_e         code_q;
  key_code_e         csi_key;
  logic [RUNE_W-1:0] rune_q;
  logic              ev_valid_q;
  logic              err_q;
  logic              cr_seen;

  logic out_free;
  logic accept;
  logic esc_clear;
  logic esc_tick;
  logic esc_expire;
  logic esc_full;

`ifdef TERM_KEY_UTF8_EN
  logic [20:0] acc_q;
  logic [1:0]  remain_q;
  logic [20:0] acc_next;

  assign acc_next = {acc_q[14:0], in_data[5:0]};
`endif

  // The output register frees this cycle when empty or being taken.
  assign out_free  = !ev_valid_q || ev_ready;
  // A serviced-late ESC timeout owns the output slot before any new byte.
  assign in_ready  = out_free && !((state == ST_ESC) && esc_full);
  assign accept    = in_valid && in_ready;
  assign esc_clear = accept && (state == ST_IDLE) && (in_data == ASCII_ESC);
  assign esc_tick  = (state == ST_ESC) && !accept;

  term_esc_timer #(
    .ESC_TIMEOUT (ESC_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_esc_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (esc_clear),
    .tick   (esc_tick),
    .expire (esc_expire),
    .full   (esc_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ev_valid_q <= 1'b0;
      code_q     <= KEY_CHAR;
      rune_q     <= '0;
      err_q      <= 1'b0;
      cr_seen    <= 1'b0;
      csi_key    <= KEY_HOME;
`ifdef TERM_KEY_UTF8_EN
      acc_q      <= '0;
      remain_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      if (ev_ready) begin
        ev_valid_q <= 1'b0;
      end

      if (accept) begin
        cr_seen <= (in_data == ASCII_CR);
        case (state)
          ST_IDLE: begin
            if (in_data == ASCII_ESC) begin
              state <= ST_ESC;
            end else if ((in_data == ASCII_CR) || ((in_data == ASCII_LF) && !cr_seen)) begin
              ev_valid_q <= 1'b1;
              code_q     <= KEY_ENTER;
              rune_q     <= '0;
            end else if ((in_data == ASCII_BS) || (in_data == ASCII_DEL)) begin
              ev_valid_q <= 1'b1;
              code_q     <= KEY_BS;
              rune_q     <= '0;
            end else if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
              ev_valid_q <= 1'b1;
              code_q     <= KEY_CHAR;
              rune_q     <= RUNE_W'(in_data);
            end else if (in_data[7]) begin
`ifdef TERM_KEY_UTF8_EN
              // Lead byte length decides how many continuation bytes follow.
              if (in_data[7:5] == 3'b110) begin
                acc_q    <= {16'd0, in_data[4:0]};
                remain_q <= 2'd1;
                state    <= ST_UTF8_CONT;
              end else if (in_data[7:4] == 4'b1110) begin
                acc_q    <= {17'd0, in_data[3:0]};
                remain_q <= 2'd2;
                state    <= ST_UTF8_CONT;
              end else if (in_data[7:3] == 5'b11110) begin
                acc_q    <= {18'd0, in_data[2:0]};
                remain_q <= 2'd3;
                state    <= ST_UTF8_CONT;
              end else begin
                err_q <= 1'b1;
              end
`else
              err_q <= 1'b1;
`endif
            end
            // Remaining control bytes, and LF right after CR, vanish quietly.
          end

          ST_ESC: begin
            if ((in_data == ASCII_LBRACKET) || (in_data == ASCII_O)) begin
              state <= ST_CSI;
            end else begin
              err_q <= 1'b1;
              state <= ST_IDLE;
            end
          end

          ST_CSI: begin
            state <= ST_IDLE;
            case (in_data)
              8'h41: begin ev_valid_q <= 1'b1; code_q <= KEY_UP;    rune_q <= '0; end
              8'h42: begin ev_valid_q <= 1'b1; code_q <= KEY_DOWN;  rune_q <= '0; end
              8'h43: begin ev_valid_q <= 1'b1; code_q <= KEY_RIGHT; rune_q <= '0; end
              8'h44: begin ev_valid_q <= 1'b1; code_q <= KEY_LEFT;  rune_q <= '0; end
              8'h48: begin ev_valid_q <= 1'b1; code_q <= KEY_HOME;  rune_q <= '0; end
              8'h46: begin ev_valid_q <= 1'b1; code_q <= KEY_END;   rune_q <= '0; end
              8'h31, 8'h32, 8'h33, 8'h34: begin
                csi_key <= csi_tilde_key(in_data);
                state   <= ST_CSI_NUM;
              end
              default: err_q <= 1'b1;
            endcase
          end

          ST_CSI_NUM: begin
            state <= ST_IDLE;
            if (in_data == ASCII_TILDE) begin
              ev_valid_q <= 1'b1;
              code_q     <= csi_key;
              rune_q     <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end

`ifdef TERM_KEY_UTF8_EN
          ST_UTF8_CONT: begin
            if (in_data[7:6] == 2'b10) begin
              if (remain_q == 2'd1) begin
                ev_valid_q <= 1'b1;
                code_q     <= KEY_CHAR;
                rune_q     <= acc_next;
                state      <= ST_IDLE;
              end else begin
                acc_q    <= acc_next;
                remain_q <= remain_q - 2'd1;
              end
            end else begin
              // The partial character and the offending byte are both lost.
              err_q <= 1'b1;
              state <= ST_IDLE;
            end
          end
`endif

          default: state <= ST_IDLE;
        endcase
      end else if ((state == ST_ESC) && esc_expire && out_free) begin
        ev_valid_q <= 1'b1;
        code_q     <= KEY_ESC;
        rune_q     <= '0;
        state      <= ST_IDLE;
      end
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_code   = code_q;
  assign ev_rune   = 21'(rune_q);
  assign err_pulse = err_q;

endmodule

// File: tb/tb_term_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_term_key_decoder
// Directed bench for term_key_decoder: a table of byte sequences with their
// expected events and error counts, plus hand-written sequences for latency,
// ESC timeout, output back-pressure and reset in the middle of a sequence.
// ---------------------------------------------------------------------------
module tb_term_key_decoder;

  localparam logic [3:0] C_CHAR  = 4'd0;
  localparam logic [3:0] C_LEFT  = 4'd1;
  localparam logic [3:0] C_RIGHT = 4'd2;
  localparam logic [3:0] C_UP    = 4'd3;
  localparam logic [3:0] C_DOWN  = 4'd4;
  localparam logic [3:0] C_BS    = 4'd5;
  localparam logic [3:0] C_DEL   = 4'd6;
  localparam logic [3:0] C_ENTER = 4'd7;
  localparam logic [3:0] C_INS   = 4'd8;
  localparam logic [3:0] C_ESC   = 4'd9;
  localparam logic [3:0] C_HOME  = 4'd10;
  localparam logic [3:0] C_END   = 4'd11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_code;
  logic [20:0] ev_rune;
  logic        err_pulse;

  always #5 clk = ~clk;

  term_key_decoder #(
    .ESC_TIMEOUT (1000),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_rune   (ev_rune),
    .err_pulse (err_pulse)
  );

  typedef struct {
    string           name;
    int              n;
    logic [3:0][7:0] b;
    int              nev;
    logic [3:0]      code;
    logic [20:0]     rune;
    int              nerr;
  } vec_t;

  vec_t        vecs[$];
  logic [3:0]  got_code[$];
  logic [20:0] got_rune[$];
  int          err_cnt;
  int          total = 0;
  int          bad   = 0;

  function automatic vec_t mk(input string nm, input int n,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int nev, input logic [3:0] code,
                              input logic [20:0] rune, input int nerr);
    vec_t v;
    v.name = nm;
    v.n    = n;
    v.b    = {b3, b2, b1, b0};
    v.nev  = nev;
    v.code = code;
    v.rune = rune;
    v.nerr = nerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge with inputs already driven.
  task automatic tick(output logic acc);
    #1;
    acc = in_valid && in_ready;
    if (ev_valid && ev_ready) begin
      got_code.push_back(ev_code);
      got_rune.push_back(ev_rune);
    end
    @(posedge clk);
    #1;
    if (err_pulse) err_cnt++;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int   tries;
    in_valid = 1'b1;
    in_data  = b;
    acc      = 1'b0;
    tries    = 0;
    while (!acc && tries < 50) begin
      tick(acc);
      tries++;
    end
    in_valid = 1'b0;
    check("send_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic clear_sb();
    got_code.delete();
    got_rune.delete();
    err_cnt = 0;
  endtask

  initial begin
    logic acc;
    int   k;
    logic found;

    // Directed vectors in the order applied; each ends back in IDLE.
    vecs.push_back(mk("char_a",    1, 8'h61, 8'h00, 8'h00, 8'h00, 1, C_CHAR,  21'h61, 0));
    vecs.push_back(mk("space",     1, 8'h20, 8'h00, 8'h00, 8'h00, 1, C_CHAR,  21'h20, 0));
    vecs.push_back(mk("left",      3, 8'h1B, 8'h5B, 8'h44, 8'h00, 1, C_LEFT,  21'h0,  0));
    vecs.push_back(mk("up_ss3",    3, 8'h1B, 8'h4F, 8'h41, 8'h00, 1, C_UP,    21'h0,  0));
    vecs.push_back(mk("right",     3, 8'h1B, 8'h5B, 8'h43, 8'h00, 1, C_RIGHT, 21'h0,  0));
    vecs.push_back(mk("down",      3, 8'h1B, 8'h5B, 8'h42, 8'h00, 1, C_DOWN,  21'h0,  0));
    vecs.push_back(mk("home_h",    3, 8'h1B, 8'h5B, 8'h48, 8'h00, 1, C_HOME,  21'h0,  0));
    vecs.push_back(mk("end_f",     3, 8'h1B, 8'h5B, 8'h46, 8'h00, 1, C_END,   21'h0,  0));
    vecs.push_back(mk("home_1",    4, 8'h1B, 8'h5B, 8'h31, 8'h7E, 1, C_HOME,  21'h0,  0));
    vecs.push_back(mk("ins_2",     4, 8'h1B, 8'h5B, 8'h32, 8'h7E, 1, C_INS,   21'h0,  0));
    vecs.push_back(mk("del_3",     4, 8'h1B, 8'h5B, 8'h33, 8'h7E, 1, C_DEL,   21'h0,  0));
    vecs.push_back(mk("end_4",     4, 8'h1B, 8'h5B, 8'h34, 8'h7E, 1, C_END,   21'h0,  0));
    vecs.push_back(mk("bs_08",     1, 8'h08, 8'h00, 8'h00, 8'h00, 1, C_BS,    21'h0,  0));
    vecs.push_back(mk("bs_7f",     1, 8'h7F, 8'h00, 8'h00, 8'h00, 1, C_BS,    21'h0,  0));
    vecs.push_back(mk("crlf",      2, 8'h0D, 8'h0A, 8'h00, 8'h00, 1, C_ENTER, 21'h0,  0));
    vecs.push_back(mk("lf_alone",  1, 8'h0A, 8'h00, 8'h00, 8'h00, 1, C_ENTER, 21'h0,  0));
    vecs.push_back(mk("cr_x_lf",   3, 8'h0D, 8'h61, 8'h0A, 8'h00, 3, C_ENTER, 21'h0,  0));
    vecs.push_back(mk("ctl_drop",  2, 8'h01, 8'h1F, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  0));
    vecs.push_back(mk("esc_bad",   2, 8'h1B, 8'h41, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("csi_bad",   3, 8'h1B, 8'h5B, 8'h5A, 8'h00, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("csi_5",     4, 8'h1B, 8'h5B, 8'h35, 8'h7E, 1, C_CHAR,  21'h7E, 1));
    vecs.push_back(mk("csinum_2d", 4, 8'h1B, 8'h5B, 8'h31, 8'h31, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("tilde",     1, 8'h7E, 8'h00, 8'h00, 8'h00, 1, C_CHAR,  21'h7E, 0));
`ifdef TERM_KEY_UTF8_EN
    vecs.push_back(mk("utf8_euro", 3, 8'hE2, 8'h82, 8'hAC, 8'h00, 1, C_CHAR,  21'h20AC, 0));
    vecs.push_back(mk("utf8_2b",   2, 8'hC3, 8'hA9, 8'h00, 8'h00, 1, C_CHAR,  21'h00E9, 0));
    vecs.push_back(mk("utf8_4b",   4, 8'hF0, 8'h9F, 8'h98, 8'h80, 1, C_CHAR,  21'h1F600, 0));
    vecs.push_back(mk("utf8_brk",  2, 8'hE2, 8'h41, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("utf8_cont", 1, 8'h80, 8'h00, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("utf8_ff",   1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  1));
`else
    vecs.push_back(mk("hi_e2",     1, 8'hE2, 8'h00, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("hi_80",     1, 8'h80, 8'h00, 8'h00, 8'h00, 0, C_CHAR,  21'h0,  1));
    vecs.push_back(mk("hi_after",  2, 8'hC3, 8'h62, 8'h00, 8'h00, 1, C_CHAR,  21'h62, 1));
`endif

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ev_ready = 1'b1;
    err_cnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_ev_code",  {28'd0, ev_code}, 32'd0);
    check("rst_ev_rune",  {11'd0, ev_rune}, 32'd0);
    check("rst_err",      {31'd0, err_pulse}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors with the consumer always ready.
    for (int i = 0; i < vecs.size(); i++) begin
      clear_sb();
      ev_ready = 1'b1;
      for (int j = 0; j < vecs[i].n; j++) send(vecs[i].b[j]);
      idle(3);
      check({vecs[i].name, "/events"}, got_code.size(), vecs[i].nev);
      if (vecs[i].nev > 0 && got_code.size() > 0) begin
        check({vecs[i].name, "/code"}, {28'd0, got_code[got_code.size()-1]}, {28'd0, vecs[i].code});
        check({vecs[i].name, "/rune"}, {11'd0, got_rune[got_rune.size()-1]}, {11'd0, vecs[i].rune});
      end
      check({vecs[i].name, "/errors"}, err_cnt, vecs[i].nerr);
    end

    // LEFT appears the cycle after the final byte's handshake.
    clear_sb();
    send(8'h1B);
    send(8'h5B);
    in_valid = 1'b1;
    in_data  = 8'h44;
    tick(acc);
    in_valid = 1'b0;
    check("lat_accept",   {31'd0, acc}, 32'd1);
    check("lat_ev_valid", {31'd0, ev_valid}, 32'd1);
    check("lat_ev_code",  {28'd0, ev_code}, {28'd0, C_LEFT});
    idle(2);
    check("lat_events",   got_code.size(), 1);
    check("lat_errors",   err_cnt, 0);

    // Lone ESC: event shows after exactly 1000 idle cycles.
    clear_sb();
    send(8'h1B);
    k     = 0;
    found = 1'b0;
    while (k < 1100 && !found) begin
      tick(acc);
      k++;
      if (ev_valid) found = 1'b1;
    end
    check("esc_to_seen",  {31'd0, found}, 32'd1);
    check("esc_to_cycle", k, 1000);
    check("esc_to_code",  {28'd0, ev_code}, {28'd0, C_ESC});
    idle(2);
    check("esc_to_events", got_code.size(), 1);

    // '[' on idle cycle 999 beats the timeout; FSM must then be in CSI.
    clear_sb();
    send(8'h1B);
    idle(998);
    send(8'h5B);
    idle(200);
    check("esc_999_no_ev", got_code.size(), 0);
    send(8'h41);
    idle(2);
    check("esc_999_events", got_code.size(), 1);
    if (got_code.size() > 0)
      check("esc_999_code", {28'd0, got_code[0]}, {28'd0, C_UP});

    // Back-pressure: ENTER held for 5 cycles blocks further input.
    clear_sb();
    ev_ready = 1'b0;
    send(8'h0D);
    in_valid = 1'b1;
    in_data  = 8'h0A;
    for (int s = 0; s < 5; s++) begin
      tick(acc);
      check("stall_in_ready", {31'd0, acc}, 32'd0);
    end
    check("stall_hold_code", {28'd0, ev_code}, {28'd0, C_ENTER});
    ev_ready = 1'b1;
    send(8'h0A);
    send(8'h61);
    send(8'h7F);
    idle(3);
    check("stall_events", got_code.size(), 3);
    if (got_code.size() == 3) begin
      check("stall_ev0", {28'd0, got_code[0]}, {28'd0, C_ENTER});
      check("stall_ev1", {28'd0, got_code[1]}, {28'd0, C_CHAR});
      check("stall_ev1_rune", {11'd0, got_rune[1]}, 32'h61);
      check("stall_ev2", {28'd0, got_code[2]}, {28'd0, C_BS});
    end

    // Reset drops a held event immediately.
    clear_sb();
    ev_ready = 1'b0;
    send(8'h62);
    check("rst_held_pre", {31'd0, ev_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_held_async", {31'd0, ev_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ev_ready = 1'b1;

    // Reset in the middle of "ESC [" forgets the sequence.
    clear_sb();
    send(8'h1B);
    send(8'h5B);
    rst = 1'b1;
    #1;
    check("rst_mid_ev_valid", {31'd0, ev_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h41);
    idle(3);
    check("rst_mid_events", got_code.size(), 1);
    if (got_code.size() > 0) begin
      check("rst_mid_code", {28'd0, got_code[0]}, {28'd0, C_CHAR});
      check("rst_mid_rune", {11'd0, got_rune[0]}, 32'h41);
    end
    check("rst_mid_errors", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
